// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Iterative integer divider covering the RISC-V style DIV / DIVU / REM / REMU
// operations. A restoring divide runs on operand magnitudes, and the final
// sign fix-up is applied when the result is captured. Divide-by-zero and
// signed overflow (most-negative / -1) skip the iteration and finish at once.
//
// Configuration macro:
//   DIV_UNIT_RADIX4_EN - when defined, two quotient bits are retired per
//                        BUSY cycle (XLEN must be even). When undefined, the
//                        divider retires one bit per cycle.
//
// Ports:
//   clk            in   1     clock, rising edge
//   rst            in   1     asynchronous active-low reset
//   div_in_rdata1  in   XLEN  dividend
//   div_in_rdata2  in   XLEN  divisor
//   div_in_enable  in   1     level request, held high while the issuer waits
//   div_in_div_op  in   4     one-hot opcode: [0] DIV [1] DIVU [2] REM [3] REMU
//   div_out_ready  out  1     one-cycle result-valid strobe
//   div_out_result out  XLEN  quotient or remainder (held between strobes)
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] div_in_rdata1,
    input  logic [XLEN-1:0] div_in_rdata2,
    input  logic            div_in_enable,
    input  logic [3:0]      div_in_div_op,
    output logic            div_out_ready,
    output logic [XLEN-1:0] div_out_result
);

`ifdef DIV_UNIT_RADIX4_EN
    localparam int STEPS = XLEN / 2;

    // Two bits per cycle only lines up with the operand width when it is even.
    if ((XLEN % 2) != 0) begin : gOddXlen
        $error("div_unit: XLEN must be even when DIV_UNIT_RADIX4_EN is defined");
    end
`else
    localparam int STEPS = XLEN;
`endif

    localparam int CW = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dvsr_q;
    logic [CW-1:0]   cnt_q;
    logic            isRem_q;
    logic            negQuot_q;
    logic            negRem_q;
    logic            ready_q;
    logic [XLEN-1:0] result_q;

    logic            opIsRem;
    logic            opIsSigned;
    logic            dividendNeg;
    logic            divisorNeg;
    logic [XLEN-1:0] dividendMag;
    logic [XLEN-1:0] divisorMag;
    logic            divByZero;
    logic            signedOverflow;
    logic [XLEN-1:0] specialResult;

    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quot_d;
    logic [XLEN-1:0] finalResult;

    // One restoring step: bring the next dividend bit (MSB of the quotient
    // shift register) into the partial remainder and subtract the divisor if
    // it fits. The borrow out of the XLEN+1 bit subtraction decides the bit.
    function automatic logic [2*XLEN-1:0] divStep(
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] quot,
        input logic [XLEN-1:0] dvsr
    );
        logic [XLEN:0] trial;
        logic [XLEN:0] diff;
        trial = {rem, quot[XLEN-1]};
        diff  = trial - {1'b0, dvsr};
        if (!diff[XLEN]) begin
            divStep = {diff[XLEN-1:0], quot[XLEN-2:0], 1'b1};
        end else begin
            divStep = {trial[XLEN-1:0], quot[XLEN-2:0], 1'b0};
        end
    endfunction

    // Opcode decode: anything that is not exactly one of the four one-hot
    // codes falls back to DIVU (unsigned quotient).
    always_comb begin
        opIsRem    = 1'b0;
        opIsSigned = 1'b0;
        case (div_in_div_op)
            4'b0001: opIsSigned = 1'b1;
            4'b0100: begin
                opIsRem    = 1'b1;
                opIsSigned = 1'b1;
            end
            4'b1000: opIsRem = 1'b1;
            default: ;
        endcase
    end

    // Operand magnitudes and the two cases that finish without iterating.
    always_comb begin
        dividendNeg    = opIsSigned & div_in_rdata1[XLEN-1];
        divisorNeg     = opIsSigned & div_in_rdata2[XLEN-1];
        dividendMag    = dividendNeg ? -div_in_rdata1 : div_in_rdata1;
        divisorMag     = divisorNeg  ? -div_in_rdata2 : div_in_rdata2;
        divByZero      = (div_in_rdata2 == '0);
        signedOverflow = opIsSigned && (div_in_rdata1 == MOST_NEG) && (div_in_rdata2 == '1);
        if (divByZero) begin
            specialResult = opIsRem ? div_in_rdata1 : '1;
        end else begin
            specialResult = opIsRem ? '0 : MOST_NEG;
        end
    end

    // Next iteration of the divider datapath, one or two steps per cycle.
    always_comb begin
        logic [2*XLEN-1:0] stepOne;
`ifdef DIV_UNIT_RADIX4_EN
        logic [2*XLEN-1:0] stepTwo;
`endif
        stepOne = divStep(rem_q, quot_q, dvsr_q);
`ifdef DIV_UNIT_RADIX4_EN
        stepTwo = divStep(stepOne[2*XLEN-1:XLEN], stepOne[XLEN-1:0], dvsr_q);
        rem_d   = stepTwo[2*XLEN-1:XLEN];
        quot_d  = stepTwo[XLEN-1:0];
`else
        rem_d   = stepOne[2*XLEN-1:XLEN];
        quot_d  = stepOne[XLEN-1:0];
`endif
    end

    // Sign fix-up applied to the values produced by the last iteration:
    // the quotient is negated when operand signs differ, the remainder
    // follows the dividend's sign.
    always_comb begin
        if (isRem_q) begin
            finalResult = negRem_q ? -rem_d : rem_d;
        end else begin
            finalResult = negQuot_q ? -quot_d : quot_d;
        end
    end

    // Control FSM with registered ready/result. DONE always lasts a single
    // cycle and ignores enable, so a held request is only re-accepted in the
    // IDLE cycle that follows. Dropping enable while BUSY abandons the work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            isRem_q   <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_in_enable) begin
                        if (divByZero || signedOverflow) begin
                            result_q <= specialResult;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rem_q     <= '0;
                            quot_q    <= dividendMag;
                            dvsr_q    <= divisorMag;
                            cnt_q     <= CW'(STEPS);
                            isRem_q   <= opIsRem;
                            negQuot_q <= dividendNeg ^ divisorNeg;
                            negRem_q  <= dividendNeg;
                            state_q   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!div_in_enable) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_q <= finalResult;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_out_ready  = ready_q;
    assign div_out_result = result_q;

endmodule
